mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_pkg.sv | 32 +++
 rtl/load_align.sv | 31 +++
 rtl/mem_access_unit.sv | 142 ++++++++++++++
 tb/tb_mem_access_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: access-size encodings,
// FSM state type and small address helpers.
package mem_pkg;

    localparam logic [1:0] MASK_BYTE = 2'b00;
    localparam logic [1:0] MASK_HALF = 2'b01;
    localparam logic [1:0] MASK_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } mem_state_e;

    function automatic logic is_misaligned(input logic [1:0] mask, input logic [1:0] off);
        case (mask)
            MASK_BYTE: return 1'b0;
            MASK_HALF: return off[0];
            default:   return (off != 2'b00);
        endcase
    endfunction

    // Round a byte offset down to the natural alignment of the access size.
    function automatic logic [1:0] align_offset(input logic [1:0] mask, input logic [1:0] off);
        case (mask)
            MASK_BYTE: return off;
            MASK_HALF: return {off[1], 1'b0};
            default:   return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane selection and sign/zero extension of a bus read word.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  mask,
    input  logic        load_unsigned,
    output logic [31:0] data
);

    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] byte_ext;
    logic signed [31:0] half_ext;

    always_comb begin
        shifted  = rdata >> {offset, 3'b000};
        byte_s   = shifted[7:0];
        half_s   = shifted[15:0];
        byte_ext = byte_s;
        half_ext = half_s;
        case (mask)
            MASK_BYTE: data = load_unsigned ? {24'h0, shifted[7:0]}  : byte_ext;
            MASK_HALF: data = load_unsigned ? {16'h0, shifted[15:0]} : half_ext;
            default:   data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data bus master: issues loads/stores, stalls the pipeline, aligns loads.
// Optional macro MEM_MISALIGN_TRAP_EN blocks misaligned accesses instead of aligning them.
module mem_access_unit
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] ex_mem_alu_result,
    input  logic        ex_mem_mem_read,
    input  logic        ex_mem_mem_write,
    input  logic [1:0]  ex_mem_mem_data_mask,
    input  logic [31:0] ex_mem_mem_write_data,
    input  logic        ex_mem_mem_unsigned,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] mem_load_data,
    output logic        mem_stall,
    output logic        mem_misaligned
);

    mem_state_e  state, state_nxt;
    logic        access, blocked, issue, mis_flag;
    logic [1:0]  off_eff;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, addr_c, aligned_data;

    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic        we_q, uns_q;
    logic [1:0]  off_q, mask_q;

    assign access = ex_mem_mem_read | ex_mem_mem_write;
    assign addr_c = {ex_mem_alu_result[31:2], 2'b00};

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_flag = access & is_misaligned(ex_mem_mem_data_mask, ex_mem_alu_result[1:0]);
    assign blocked  = mis_flag;
    assign off_eff  = ex_mem_alu_result[1:0];
`else
    assign mis_flag = 1'b0;
    assign blocked  = 1'b0;
    assign off_eff  = align_offset(ex_mem_mem_data_mask, ex_mem_alu_result[1:0]);
`endif

    assign issue = rstn & (state == ST_IDLE) & access & ~blocked;

    always_comb begin
        case (ex_mem_mem_data_mask)
            MASK_BYTE: begin
                be_c    = 4'b0001 << off_eff;
                wdata_c = {4{ex_mem_mem_write_data[7:0]}};
            end
            MASK_HALF: begin
                be_c    = 4'b0011 << off_eff;
                wdata_c = {2{ex_mem_mem_write_data[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = ex_mem_mem_write_data;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Request snapshot: keeps the bus stable in REQ and steers the load result in WAIT.
    always_ff @(posedge clk) begin
        if (issue) begin
            addr_q  <= addr_c;
            wdata_q <= wdata_c;
            be_q    <= be_c;
            we_q    <= ex_mem_mem_write;
            off_q   <= off_eff;
            mask_q  <= ex_mem_mem_data_mask;
            uns_q   <= ex_mem_mem_unsigned;
        end
    end

    load_align u_load_align (
        .rdata         (dmem_rdata),
        .offset        (off_q),
        .mask          (mask_q),
        .load_unsigned (uns_q),
        .data          (aligned_data)
    );

    always_comb begin
        state_nxt      = state;
        dmem_req       = 1'b0;
        dmem_we        = 1'b0;
        dmem_addr      = 32'h0;
        dmem_be        = 4'b0000;
        dmem_wdata     = 32'h0;
        mem_stall      = 1'b0;
        mem_misaligned = 1'b0;
        mem_load_data  = 32'h0;
        if (rstn) begin
            case (state)
                ST_IDLE: begin
                    mem_misaligned = mis_flag;
                    if (issue) begin
                        dmem_req   = 1'b1;
                        dmem_we    = ex_mem_mem_write;
                        dmem_addr  = addr_c;
                        dmem_be    = be_c;
                        dmem_wdata = wdata_c;
                        mem_stall  = ~(ex_mem_mem_write & dmem_ready);
                        if (!dmem_ready)          state_nxt = ST_REQ;
                        else if (ex_mem_mem_read) state_nxt = ST_WAIT;
                    end
                end
                ST_REQ: begin
                    dmem_req   = 1'b1;
                    dmem_we    = we_q;
                    dmem_addr  = addr_q;
                    dmem_be    = be_q;
                    dmem_wdata = wdata_q;
                    mem_stall  = ~(we_q & dmem_ready);
                    if (dmem_ready) state_nxt = we_q ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    mem_stall = ~dmem_rvalid;
                    if (dmem_rvalid) begin
                        mem_load_data = aligned_data;
                        state_nxt     = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a transaction-level model.
module tb_mem_access_unit;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] ex_mem_alu_result;
    logic        ex_mem_mem_read, ex_mem_mem_write, ex_mem_mem_unsigned;
    logic [1:0]  ex_mem_mem_data_mask;
    logic [31:0] ex_mem_mem_write_data;
    logic        dmem_req, dmem_we, dmem_ready, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, mem_load_data;
    logic [3:0]  dmem_be;
    logic        mem_stall, mem_misaligned;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .ex_mem_alu_result     (ex_mem_alu_result),
        .ex_mem_mem_read       (ex_mem_mem_read),
        .ex_mem_mem_write      (ex_mem_mem_write),
        .ex_mem_mem_data_mask  (ex_mem_mem_data_mask),
        .ex_mem_mem_write_data (ex_mem_mem_write_data),
        .ex_mem_mem_unsigned   (ex_mem_mem_unsigned),
        .dmem_req              (dmem_req),
        .dmem_we               (dmem_we),
        .dmem_addr             (dmem_addr),
        .dmem_be               (dmem_be),
        .dmem_wdata            (dmem_wdata),
        .dmem_ready            (dmem_ready),
        .dmem_rvalid           (dmem_rvalid),
        .dmem_rdata            (dmem_rdata),
        .mem_load_data         (mem_load_data),
        .mem_stall             (mem_stall),
        .mem_misaligned        (mem_misaligned)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [1:0] m);
        return (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input int off, input int sz,
                                               input bit uns);
        logic [63:0] v, lane_mask;
        lane_mask = (64'd1 << (8 * sz)) - 64'd1;
        v = ({32'h0, rd} >> (8 * off)) & lane_mask;
        if (!uns && v[8 * sz - 1]) v = v | ~lane_mask;
        return v[31:0];
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_req"},   dmem_req, 1'b0);
        check({tag, "_stall"}, mem_stall, 1'b0);
        check({tag, "_ld"},    mem_load_data, 32'h0);
    endtask

    // One transaction at a negedge; bus grants after rdly refused cycles, load data rvld cycles later.
    task automatic access(input logic [31:0] a, input bit wr, input logic [1:0] m,
                          input logic [31:0] wd, input bit uns, input int rdly, input int rvld,
                          input logic [31:0] rd, input bit noise);
        int sz, off;
        bit mis;
        logic [31:0] exp_wd;
        sz  = size_of(m);
        mis = (a % 4) % sz != 0;
        off = ((a % 4) / sz) * sz;
        exp_wd = (sz == 1) ? wd[7:0] * 32'h01010101 : (sz == 2) ? wd[15:0] * 32'h00010001 : wd;

        ex_mem_alu_result     = a;
        ex_mem_mem_read       = !wr;
        ex_mem_mem_write      = wr;
        ex_mem_mem_data_mask  = m;
        ex_mem_mem_write_data = wd;
        ex_mem_mem_unsigned   = uns;

        if (TRAP_EN && mis) begin
            dmem_ready  = 1'($urandom);
            dmem_rvalid = 1'b0;
            #1;
            check("trap_req", dmem_req, 1'b0);
            check("trap_stall", mem_stall, 1'b0);
            check("trap_mis", mem_misaligned, 1'b1);
            @(posedge clk); @(negedge clk);
        end else begin
            for (int k = 0; k <= rdly; k++) begin
                dmem_ready  = (k == rdly);
                dmem_rvalid = noise ? 1'($urandom) : 1'b0;
                dmem_rdata  = $urandom;
                #1;
                check("req", dmem_req, 1'b1);
                check("we", dmem_we, wr);
                check("addr", dmem_addr, a & ~32'h3);
                check("be", dmem_be, ((1 << sz) - 1) << off);
                if (wr) check("wdata", dmem_wdata, exp_wd);
                check("stall_req", mem_stall, !(wr && k == rdly));
                check("mis_req", mem_misaligned, 1'b0);
                check("ld_req", mem_load_data, 32'h0);
                @(posedge clk); @(negedge clk);
            end
            if (!wr) begin
                for (int j = 1; j <= rvld; j++) begin
                    dmem_ready  = 1'($urandom);
                    dmem_rvalid = (j == rvld);
                    dmem_rdata  = (j == rvld) ? rd : $urandom;
                    #1;
                    check("req_wait", dmem_req, 1'b0);
                    check("stall_wait", mem_stall, j < rvld);
                    check("ld_wait", mem_load_data, (j == rvld) ? model_load(rd, off, sz, uns) : 32'h0);
                    @(posedge clk); @(negedge clk);
                end
            end
        end
        ex_mem_mem_read  = 1'b0;
        ex_mem_mem_write = 1'b0;
        dmem_rvalid      = noise ? 1'($urandom) : 1'b0;
        dmem_ready       = 1'($urandom);
        #1;
        check_quiet("idle");
        check("idle_mis", mem_misaligned, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        rstn                  = 1'b0;
        ex_mem_alu_result     = 32'h4;
        ex_mem_mem_read       = 1'b1;
        ex_mem_mem_write      = 1'b0;
        ex_mem_mem_data_mask  = 2'b10;
        ex_mem_mem_write_data = 32'h0;
        ex_mem_mem_unsigned   = 1'b0;
        dmem_ready            = 1'b1;
        dmem_rvalid           = 1'b1;
        dmem_rdata            = 32'hFFFF_FFFF;
        @(negedge clk); #1;
        check("rst_req", dmem_req, 1'b0);
        check("rst_we", dmem_we, 1'b0);
        check("rst_be", dmem_be, 4'h0);
        check("rst_stall", mem_stall, 1'b0);
        check("rst_mis", mem_misaligned, 1'b0);
        check("rst_ld", mem_load_data, 32'h0);
        @(negedge clk);
        ex_mem_mem_read = 1'b0;
        dmem_rvalid     = 1'b0;
        rstn            = 1'b1;
        #1 check_quiet("post_rst");
        @(negedge clk);

        // Directed scenarios
        access(32'h1003, 1'b1, 2'b00, 32'h0000_00AB, 1'b0, 0, 1, 32'h0, 1'b0);
        access(32'h2002, 1'b0, 2'b01, 32'h0, 1'b0, 0, 1, 32'h8001_0000, 1'b0);
        access(32'h0001, 1'b0, 2'b00, 32'h0, 1'b1, 3, 2, 32'h1234_F678, 1'b1);
        access(32'h0002, 1'b0, 2'b10, 32'h0, 1'b0, 0, 1, 32'hCAFE_BABE, 1'b0);
        access(32'h0003, 1'b1, 2'b01, 32'h0000_BEEF, 1'b0, 1, 1, 32'h0, 1'b0);

        // Reset while waiting for a load response; the late response must be dropped
        ex_mem_alu_result    = 32'h2002;
        ex_mem_mem_read      = 1'b1;
        ex_mem_mem_data_mask = 2'b01;
        dmem_ready           = 1'b1;
        dmem_rvalid          = 1'b0;
        @(posedge clk); @(negedge clk);
        #1 check("wait_stall", mem_stall, 1'b1);
        rstn = 1'b0;
        #1;
        check_quiet("rst_wait");
        @(posedge clk); @(negedge clk);
        rstn            = 1'b1;
        ex_mem_mem_read = 1'b0;
        dmem_rvalid     = 1'b1;
        dmem_rdata      = 32'hDEAD_BEEF;
        #1 check_quiet("late_rvalid");
        @(negedge clk);
        dmem_rvalid = 1'b0;
        access(32'h0010, 1'b0, 2'b10, 32'h0, 1'b0, 0, 1, 32'h0BAD_F00D, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            access($urandom, 1'($urandom), 2'($urandom), $urandom, 1'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), $urandom, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
